// File: rtl/shift_demo_ctrl.sv
// shift_demo_ctrl: run/stop, speed-selectable step scheduler shifting a WIDTH-bit LED pattern
// FILL mode (3) is built only when SHIFT_FILL_MODE_EN is defined.
module shift_demo_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV_BASE = 12_500_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_stop,
  input  logic             mode_next,
  input  logic [1:0]       spd,
  output logic [WIDTH-1:0] led,
  output logic             step,
  output logic [1:0]       mode,
  output logic             running
);
  typedef enum logic [1:0] {ROT_L, ROT_R, BOUNCE, FILL} mode_t;
  mode_t mode_q, mode_nx;
  logic [31:0] cnt, period;
  logic [WIDTH-1:0] led_nx;
  logic dir, dir_nx, term;
  assign mode = mode_q;
  assign period = 32'(DIV_BASE) >> spd;
  assign term = cnt >= period - 32'd1;
`ifdef SHIFT_FILL_MODE_EN
  assign mode_nx = mode_t'(mode_q + 2'd1);
`else
  assign mode_nx = mode_q == BOUNCE ? ROT_L : mode_t'(mode_q + 2'd1);
`endif
  // dir: 0 = left, 1 = right; it flips on the step that leaves an end bit
  always_comb begin
    dir_nx = dir;
    led_nx = {led[WIDTH-2:0], led[WIDTH-1]};
    if (mode_q == ROT_R) led_nx = {led[0], led[WIDTH-1:1]};
    else if (mode_q == BOUNCE) begin
      dir_nx = dir ? !led[0] : led[WIDTH-1];
      led_nx = dir_nx ? led >> 1 : led << 1;
    end
`ifdef SHIFT_FILL_MODE_EN
    else if (mode_q == FILL) led_nx = &led ? WIDTH'(1) : {led[WIDTH-2:0], 1'b1};
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= WIDTH'(1);
      mode_q <= ROT_L;
      running <= 1'b0;
      step <= 1'b0;
      dir <= 1'b0;
      cnt <= '0;
    end else begin
      step <= 1'b0;
      if (start_stop) running <= !running;
      if (mode_next) begin
        mode_q <= mode_nx;
        led <= WIDTH'(1);
        dir <= 1'b0;
        cnt <= '0;
      end else if (!running || start_stop) cnt <= '0;
      else if (term) begin
        cnt <= '0;
        step <= 1'b1;
        led <= led_nx;
        dir <= dir_nx;
      end else cnt <= cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_shift_demo_ctrl.sv
// tb_shift_demo_ctrl: directed checks of shift_demo_ctrl with WIDTH=8, DIV_BASE=8
module tb_shift_demo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_stop = 1'b0;
  logic mode_next = 1'b0;
  logic [1:0] spd = 2'd0;
  logic [7:0] led;
  logic step;
  logic [1:0] mode;
  logic running;
  int tests = 0;
  int fails = 0;
  int c;
  int n;
  logic [7:0] rotl_tab [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] rotr_tab [4] = '{8'h80, 8'h40, 8'h20, 8'h10};
  logic [7:0] bnc_tab [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                               8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
  logic [7:0] fill_tab [8] = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h01};

  shift_demo_ctrl #(.WIDTH(8), .DIV_BASE(8)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .mode_next(mode_next),
    .spd(spd), .led(led), .step(step), .mode(mode), .running(running)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic ss, input logic mn);
    start_stop = ss;
    mode_next = mn;
    tick();
    start_stop = 1'b0;
    mode_next = 1'b0;
  endtask

  task automatic next_step(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!step && cyc < 60);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_led", led, 8'h01);
    chk("rst_mode", mode, 2'd0);
    chk("rst_running", running, 1'b0);
    chk("rst_step", step, 1'b0);
    // ROT_L at spd=0: one step per 8 cycles
    pulse(1'b1, 1'b0);
    chk("start_running", running, 1'b1);
    for (int i = 0; i < 8; i++) begin
      next_step(c);
      chk($sformatf("rotl_cyc%0d", i), c, 8);
      chk($sformatf("rotl_led%0d", i), led, rotl_tab[i]);
    end
    // stop and mode change together, then ROT_R at spd=2
    pulse(1'b1, 1'b1);
    chk("both_running", running, 1'b0);
    chk("both_mode", mode, 2'd1);
    chk("both_led", led, 8'h01);
    spd = 2'd2;
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      next_step(c);
      chk($sformatf("rotr_cyc%0d", i), c, 2);
      chk($sformatf("rotr_led%0d", i), led, rotr_tab[i]);
    end
    // BOUNCE entered while running
    pulse(1'b0, 1'b1);
    chk("bnc_running", running, 1'b1);
    chk("bnc_mode", mode, 2'd2);
    chk("bnc_led0", led, 8'h01);
    for (int i = 0; i < 16; i++) begin
      next_step(c);
      chk($sformatf("bnc_cyc%0d", i), c, 2);
      chk($sformatf("bnc_led%0d", i), led, bnc_tab[i]);
    end
    // speed raised past the current count: step on the very next edge
    spd = 2'd0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n += int'(step);
    end
    chk("spd_nostep", n, 0);
    chk("spd_hold", led, 8'h04);
    spd = 2'd3;
    tick();
    chk("spd_step", step, 1'b1);
    chk("spd_led", led, 8'h08);
    tick();
    chk("spd_step2", step, 1'b1);
    chk("spd_led2", led, 8'h10);
    pulse(1'b0, 1'b1);
    chk("mn_term_step", step, 1'b0);
    chk("mn_term_led", led, 8'h01);
`ifdef SHIFT_FILL_MODE_EN
    chk("mn_term_mode", mode, 2'd3);
`else
    chk("mn_term_mode", mode, 2'd0);
`endif
    // stop at cnt=4, hold for 20 cycles, restart
    spd = 2'd0;
    for (int i = 0; i < 4; i++) tick();
    pulse(1'b1, 1'b0);
    chk("stop_running", running, 1'b0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n += int'(step);
    end
    chk("stop_nostep", n, 0);
    chk("stop_led", led, 8'h01);
    pulse(1'b1, 1'b0);
    next_step(c);
    chk("restart_cyc", c, 8);
`ifdef SHIFT_FILL_MODE_EN
    chk("restart_led", led, 8'h03);
`else
    chk("restart_led", led, 8'h02);
`endif
    // reset mid-run
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_led", led, 8'h01);
    chk("mrst_mode", mode, 2'd0);
    chk("mrst_running", running, 1'b0);
    chk("mrst_step", step, 1'b0);
    // mode wrap
    pulse(1'b0, 1'b1);
    chk("cyc_mode1", mode, 2'd1);
    pulse(1'b0, 1'b1);
    chk("cyc_mode2", mode, 2'd2);
    pulse(1'b0, 1'b1);
`ifdef SHIFT_FILL_MODE_EN
    chk("cyc_mode3", mode, 2'd3);
    spd = 2'd3;
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      next_step(c);
      chk($sformatf("fill_cyc%0d", i), c, 1);
      chk($sformatf("fill_led%0d", i), led, fill_tab[i]);
    end
    pulse(1'b0, 1'b1);
    chk("fill_wrap_mode", mode, 2'd0);
`else
    chk("cyc_mode0", mode, 2'd0);
    chk("cyc_running", running, 1'b0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
